// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants and fetch buffer entry type
package mips_pkg;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory and decode-side signals of the fetch stage
interface fetch_stage_if;
    import mips_pkg::*;

    logic              o_imem_req;
    logic [31:0]       o_imem_addr;
    logic              i_imem_gnt;
    logic              i_imem_rvalid;
    logic [INST_W-1:0] i_imem_rdata;
    logic              i_pause;
    logic              i_redirect;
    logic [31:0]       i_redirect_pc;
    logic              o_valid;
    logic [31:0]       o_PC;
    logic [INST_W-1:0] o_inst;

    modport master (
        output o_imem_req, o_imem_addr, o_valid, o_PC, o_inst,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_pause, i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_valid, o_PC, o_inst,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_pause, i_redirect, i_redirect_pc
    );
endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - synchronous {pc, inst} FIFO; flush overrides push and pop
module fetch_buffer
    import mips_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output fetch_entry_t  head
);
    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // a full buffer still accepts a word when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch: credit-limited imem reads, buffered {PC, inst} to decode
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rstn,
    fetch_stage_if.master bus
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int SW = CW + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] inflight_next;
    logic [CW-1:0] drop;
    logic [CW-1:0] fifo_count;
    logic [SW-1:0] credit_used;
    logic          fifo_full;
    logic          fifo_empty;
    logic          accept;
    logic          pop;
    logic          push;
    fetch_entry_t  head;

    assign pop = !fifo_empty && !bus.i_pause;

    // the slot freed by this cycle's pop is reusable at once, giving 1 inst/cycle with 2 entries
    assign credit_used = SW'(inflight) + SW'(fifo_count) - SW'(pop);

    assign bus.o_imem_req  = rstn && !bus.i_redirect && (!fifo_full || pop)
                           && (credit_used < SW'(BUF_DEPTH));
    assign bus.o_imem_addr = fetch_pc;

    assign accept        = bus.o_imem_req && bus.i_imem_gnt;
    assign inflight_next = inflight + CW'(accept) - CW'(bus.i_imem_rvalid);
    assign push          = bus.i_imem_rvalid && (drop == '0) && !bus.i_redirect;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight_next;
            if (bus.i_redirect) begin
                // everything still outstanding after this edge belongs to the old path
                fetch_pc <= word_align(bus.i_redirect_pc);
                rsp_pc   <= word_align(bus.i_redirect_pc);
                drop     <= inflight_next;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                if (bus.i_imem_rvalid) begin
                    if (drop != '0) drop   <= drop - CW'(1);
                    else            rsp_pc <= rsp_pc + 32'd4;
                end
            end
        end
    end

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buffer (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (bus.i_redirect),
        .wdata ('{pc: rsp_pc, inst: bus.i_imem_rdata}),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    assign bus.o_valid = !fifo_empty;
    assign bus.o_PC    = fifo_empty ? 32'h0 : head.pc;
    assign bus.o_inst  = fifo_empty ? NOP_INST : head.inst;

    a_rvalid_needs_request: assert property (
        @(posedge clk) disable iff (!rstn) bus.i_imem_rvalid |-> (inflight != '0)
    );
endmodule
